// File: rtl/ft245_responder.sv
// Device-side model of an FT245-style asynchronous byte FIFO: serves controller reads from an
// RX buffer fed by a host stream, and captures controller writes into a TX buffer drained by the host.
module ft245_responder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int RD_DELAY    = 2,
    parameter int TXE_HOLDOFF = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] fifo_d_i,
    output logic [7:0] fifo_d_o,
    output logic       fifo_d_oe_o,
    output logic       fifo_nRXF_o,
    output logic       fifo_nTXE_o,
    input  logic       fifo_nRD_i,
    input  logic       fifo_nWD_i,
    input  logic [7:0] host_tx_data_i,
    input  logic       host_tx_valid_i,
    output logic       host_tx_ready_o,
    output logic [7:0] host_rx_data_o,
    output logic       host_rx_valid_o,
    input  logic       host_rx_ready_i,
    output logic       err_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RDW   = (RD_DELAY > 1) ? $clog2(RD_DELAY) : 1;
    localparam int HOW   = $clog2(TXE_HOLDOFF + 1);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [RDW-1:0]      RD_LOAD    = RDW'(RD_DELAY - 1);
    localparam logic [HOW-1:0]      HOLD_LOAD  = HOW'(TXE_HOLDOFF);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DRIVE,
        R_RECOVER
    } rd_state_t;

    rd_state_t rd_state, rd_state_next;
    logic [RDW-1:0] rd_cnt, rd_cnt_next;
    logic [HOW-1:0] holdoff, holdoff_next;
    logic nrd_q, nwd_q;
    logic nrd_fall, nrd_rise, nwd_fall;
    logic rd_err, wr_err;

    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count, rx_count_next;
    logic                  rx_push, rx_pop, rx_empty;

    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr, tx_rd_ptr_next;
    logic [DEPTH_LOG2:0]   tx_count, tx_count_next, tx_count_after_pop;
    logic                  tx_push, tx_pop, tx_full;

    assign nrd_fall = nrd_q & ~fifo_nRD_i;
    assign nrd_rise = ~nrd_q & fifo_nRD_i;
    assign nwd_fall = nwd_q & ~fifo_nWD_i;

    assign rx_empty = (rx_count == '0);
    assign rx_push  = host_tx_valid_i & host_tx_ready_o;
    assign rx_pop   = (rd_state == R_DRIVE) & nrd_rise;

    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_push  = nwd_fall & ~fifo_nTXE_o & ~tx_full;
    assign tx_pop   = host_rx_valid_o & host_rx_ready_i;
    assign wr_err   = nwd_fall & ~tx_push;

    assign tx_rd_ptr_next     = tx_pop ? tx_rd_ptr + 1'b1 : tx_rd_ptr;
    assign tx_count_after_pop = tx_pop ? tx_count - 1'b1 : tx_count;

    always_comb begin
        rx_count_next = rx_count;
        if (rx_push & ~rx_pop)
            rx_count_next = rx_count + 1'b1;
        else if (rx_pop & ~rx_push)
            rx_count_next = rx_count - 1'b1;
    end

    always_comb begin
        tx_count_next = tx_count;
        if (tx_push & ~tx_pop)
            tx_count_next = tx_count + 1'b1;
        else if (tx_pop & ~tx_push)
            tx_count_next = tx_count - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count_next;
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            tx_rd_ptr <= tx_rd_ptr_next;
            tx_count  <= tx_count_next;
        end
    end

    // Storage needs no reset; emptiness is carried entirely by the pointers and counts.
    always_ff @(posedge clk_i) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= host_tx_data_i;
        if (tx_push)
            tx_mem[tx_wr_ptr] <= fifo_d_i;
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_cnt_next   = rd_cnt;
        rd_err        = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (nrd_fall) begin
                    if (!fifo_nRXF_o) begin
                        rd_state_next = R_WAIT;
                        rd_cnt_next   = RD_LOAD;
                    end else begin
                        rd_err = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                if (nrd_rise) begin
                    rd_err        = 1'b1;
                    rd_state_next = R_RECOVER;
                end else if (rd_cnt == '0) begin
                    rd_state_next = R_DRIVE;
                end else begin
                    rd_cnt_next = rd_cnt - 1'b1;
                end
            end
            R_DRIVE: begin
                if (nrd_rise)
                    rd_state_next = R_RECOVER;
            end
            R_RECOVER: rd_state_next = R_IDLE;
            default:   rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        holdoff_next = holdoff;
        if (tx_push)
            holdoff_next = HOLD_LOAD;
        else if (holdoff != '0)
            holdoff_next = holdoff - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            holdoff  <= '0;
            nrd_q    <= 1'b1;
            nwd_q    <= 1'b1;
        end else begin
            rd_state <= rd_state_next;
            rd_cnt   <= rd_cnt_next;
            holdoff  <= holdoff_next;
            nrd_q    <= fifo_nRD_i;
            nwd_q    <= fifo_nWD_i;
        end
    end

    // nRXF stays high through the recover cycle and the one after it, so the controller
    // sees fresh RX-empty status only once the popped byte has settled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fifo_d_o        <= 8'h00;
            fifo_d_oe_o     <= 1'b0;
            fifo_nRXF_o     <= 1'b1;
            fifo_nTXE_o     <= 1'b1;
            host_tx_ready_o <= 1'b0;
            host_rx_data_o  <= 8'h00;
            host_rx_valid_o <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            fifo_d_oe_o     <= (rd_state_next == R_DRIVE);
            fifo_d_o        <= (rd_state_next == R_DRIVE) ? rx_mem[rx_rd_ptr] : 8'h00;
            fifo_nRXF_o     <= (rd_state != R_IDLE) | (rd_state_next != R_IDLE) | rx_empty;
            fifo_nTXE_o     <= tx_full | (holdoff != '0) | ~fifo_nWD_i;
            host_tx_ready_o <= (rx_count_next != FULL_COUNT);
            host_rx_valid_o <= (tx_count_after_pop != '0);
            host_rx_data_o  <= tx_mem[tx_rd_ptr_next];
            err_o           <= err_o | rd_err | wr_err;
        end
    end

endmodule

// File: tb/tb_ft245_responder.sv
// Directed bench for ft245_responder: a cycle-accurate vector table for reset and a two-byte
// read, then hand-written sequences for TX fill, RX wrap, protocol errors and mid-transfer reset.
module tb_ft245_responder;
    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] fifo_d_i = 8'h00;
    logic [7:0] fifo_d_o;
    logic       fifo_d_oe_o;
    logic       fifo_nRXF_o;
    logic       fifo_nTXE_o;
    logic       fifo_nRD_i = 1'b1;
    logic       fifo_nWD_i = 1'b1;
    logic [7:0] host_tx_data_i = 8'h00;
    logic       host_tx_valid_i = 1'b0;
    logic       host_tx_ready_o;
    logic [7:0] host_rx_data_o;
    logic       host_rx_valid_o;
    logic       host_rx_ready_i = 1'b0;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ft245_responder #(
        .DEPTH_LOG2 (4),
        .RD_DELAY   (2),
        .TXE_HOLDOFF(2)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .fifo_d_i       (fifo_d_i),
        .fifo_d_o       (fifo_d_o),
        .fifo_d_oe_o    (fifo_d_oe_o),
        .fifo_nRXF_o    (fifo_nRXF_o),
        .fifo_nTXE_o    (fifo_nTXE_o),
        .fifo_nRD_i     (fifo_nRD_i),
        .fifo_nWD_i     (fifo_nWD_i),
        .host_tx_data_i (host_tx_data_i),
        .host_tx_valid_i(host_tx_valid_i),
        .host_tx_ready_o(host_tx_ready_o),
        .host_rx_data_o (host_rx_data_o),
        .host_rx_valid_o(host_rx_valid_o),
        .host_rx_ready_i(host_rx_ready_i),
        .err_o          (err_o)
    );

    typedef struct packed {
        logic       rst;
        logic       nrd;
        logic       hv;
        logic [7:0] hd;
        logic       nrxf;
        logic       ntxe;
        logic       oe;
        logic [7:0] dout;
        logic       rdy;
        logic       val;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%02h expected=%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset_i         = v.rst;
        fifo_nRD_i      = v.nrd;
        host_tx_valid_i = v.hv;
        host_tx_data_i  = v.hd;
    endtask

    task automatic do_reset();
        reset_i         = 1'b1;
        fifo_nRD_i      = 1'b1;
        fifo_nWD_i      = 1'b1;
        host_tx_valid_i = 1'b0;
        host_rx_ready_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic wait_rxf_low();
        int n = 0;
        while (fifo_nRXF_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check_bit("wait_nrxf_low", fifo_nRXF_o, 1'b0);
    endtask

    task automatic wait_txe_low();
        int n = 0;
        while (fifo_nTXE_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check_bit("wait_ntxe_low", fifo_nTXE_o, 1'b0);
    endtask

    task automatic host_push(input logic [7:0] b);
        int n = 0;
        host_tx_data_i  = b;
        host_tx_valid_i = 1'b1;
        while (host_tx_ready_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_bit("push_ready", host_tx_ready_o, 1'b1);
        tick();
        host_tx_valid_i = 1'b0;
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp_byte);
        int n = 0;
        wait_rxf_low();
        fifo_nRD_i = 1'b0;
        do begin
            tick();
            n++;
        end while (fifo_d_oe_o !== 1'b1 && n < 10);
        check_bit({name, "_oe"}, fifo_d_oe_o, 1'b1);
        check_byte(name, fifo_d_o, exp_byte);
        fifo_nRD_i = 1'b1;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wait_txe_low();
        fifo_d_i   = b;
        fifo_nWD_i = 1'b0;
        tick();
        check_bit("ntxe_after_write", fifo_nTXE_o, 1'b1);
        fifo_nWD_i = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        // rst nrd hv hd | nrxf ntxe oe dout rdy val err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i]);
            tick();
            check_bit($sformatf("vec%0d_nrxf", i), fifo_nRXF_o, vecs[i].nrxf);
            check_bit($sformatf("vec%0d_ntxe", i), fifo_nTXE_o, vecs[i].ntxe);
            check_bit($sformatf("vec%0d_oe", i), fifo_d_oe_o, vecs[i].oe);
            check_byte($sformatf("vec%0d_dout", i), fifo_d_o, vecs[i].dout);
            check_bit($sformatf("vec%0d_ready", i), host_tx_ready_o, vecs[i].rdy);
            check_bit($sformatf("vec%0d_rxvalid", i), host_rx_valid_o, vecs[i].val);
            check_bit($sformatf("vec%0d_err", i), err_o, vecs[i].err);
        end

        // TX fill: first write timed by hand, then fill to capacity and overflow once.
        do_reset();
        fifo_d_i   = 8'h11;
        fifo_nWD_i = 1'b0;
        tick();
        check_bit("w_ntxe_w0", fifo_nTXE_o, 1'b1);
        check_bit("w_valid_w0", host_rx_valid_o, 1'b0);
        fifo_nWD_i = 1'b1;
        tick();
        check_bit("w_ntxe_w1", fifo_nTXE_o, 1'b1);
        check_bit("w_valid_w1", host_rx_valid_o, 1'b1);
        check_byte("w_data_w1", host_rx_data_o, 8'h11);
        tick();
        check_bit("w_ntxe_w2", fifo_nTXE_o, 1'b1);
        tick();
        check_bit("w_ntxe_w3", fifo_nTXE_o, 1'b0);
        for (int i = 1; i < 16; i++)
            write_byte(8'(8'h11 + i));
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bit("full_ntxe", fifo_nTXE_o, 1'b1);
        end
        check_bit("full_err_before", err_o, 1'b0);
        fifo_d_i   = 8'h99;
        fifo_nWD_i = 1'b0;
        tick();
        check_bit("overflow_err", err_o, 1'b1);
        fifo_nWD_i = 1'b1;
        tick();
        host_rx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_bit("drain_valid", host_rx_valid_o, 1'b1);
            check_byte("drain_data", host_rx_data_o, 8'(8'h11 + i));
            tick();
        end
        host_rx_ready_i = 1'b0;
        check_bit("drain_empty", host_rx_valid_o, 1'b0);
        tick();
        check_bit("drain_empty_later", host_rx_valid_o, 1'b0);

        // RX wrap: pushes and reads run concurrently across several pointer wraps.
        do_reset();
        fork
            begin
                for (int i = 0; i < 40; i++)
                    host_push(8'(8'h40 + i));
            end
            begin
                for (int j = 0; j < 40; j++)
                    read_byte("wrap_data", 8'(8'h40 + j));
            end
        join
        tick();
        tick();
        check_bit("wrap_nrxf_end", fifo_nRXF_o, 1'b1);
        check_bit("wrap_err", err_o, 1'b0);

        // Read strobe with RX empty.
        do_reset();
        fifo_nRD_i = 1'b0;
        tick();
        check_bit("empty_read_err", err_o, 1'b1);
        check_bit("empty_read_oe0", fifo_d_oe_o, 1'b0);
        tick();
        check_bit("empty_read_oe1", fifo_d_oe_o, 1'b0);
        fifo_nRD_i = 1'b1;
        tick();
        check_bit("empty_read_oe2", fifo_d_oe_o, 1'b0);
        check_bit("empty_read_nrxf", fifo_nRXF_o, 1'b1);

        // Read strobe released before data is driven: error, no pop.
        do_reset();
        check_bit("reset_clears_err", err_o, 1'b0);
        host_push(8'h77);
        host_push(8'h78);
        wait_rxf_low();
        fifo_nRD_i = 1'b0;
        tick();
        fifo_nRD_i = 1'b1;
        tick();
        check_bit("short_pulse_err", err_o, 1'b1);
        check_bit("short_pulse_oe", fifo_d_oe_o, 1'b0);
        check_bit("short_pulse_nrxf", fifo_nRXF_o, 1'b1);
        read_byte("retry_head", 8'h77);
        read_byte("retry_next", 8'h78);
        tick();
        tick();
        check_bit("retry_empty", fifo_nRXF_o, 1'b1);
        check_bit("retry_err_sticky", err_o, 1'b1);

        // Reset while driving data, with bytes queued in both buffers.
        do_reset();
        write_byte(8'h55);
        host_push(8'h31);
        host_push(8'h32);
        host_push(8'h33);
        check_bit("pre_reset_txvalid", host_rx_valid_o, 1'b1);
        wait_rxf_low();
        fifo_nRD_i = 1'b0;
        tick();
        tick();
        tick();
        check_bit("drive_oe", fifo_d_oe_o, 1'b1);
        check_byte("drive_data", fifo_d_o, 8'h31);
        reset_i    = 1'b1;
        fifo_nRD_i = 1'b1;
        tick();
        check_bit("mid_reset_oe", fifo_d_oe_o, 1'b0);
        check_bit("mid_reset_nrxf", fifo_nRXF_o, 1'b1);
        check_bit("mid_reset_ntxe", fifo_nTXE_o, 1'b1);
        check_bit("mid_reset_ready", host_tx_ready_o, 1'b0);
        check_bit("mid_reset_valid", host_rx_valid_o, 1'b0);
        reset_i = 1'b0;
        tick();
        check_bit("post_reset_nrxf", fifo_nRXF_o, 1'b1);
        check_bit("post_reset_ntxe", fifo_nTXE_o, 1'b0);
        check_bit("post_reset_ready", host_tx_ready_o, 1'b1);
        check_bit("post_reset_valid", host_rx_valid_o, 1'b0);
        check_bit("post_reset_err", err_o, 1'b0);
        tick();
        tick();
        check_bit("post_reset_rx_empty", fifo_nRXF_o, 1'b1);
        check_bit("post_reset_tx_empty", host_rx_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
